// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: state encodings,
// opcodes, ALU operation classes and the registered control bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS datapath. Control outputs are
// registered alongside the state; write strobes are gated off during reset.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    ctrl_t  ctrl_q;

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_RTYPE:     n = S_EXEC;
                    OP_BEQ:       n = S_BRANCH;
                    OP_J:         n = S_JUMP;
                    OP_ADDI:      n = S_ADDIEX;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  n = S_MEMWB;
            S_EXEC:   n = S_ALUWB;
            S_ADDIEX: n = S_ADDIWB;
            // Terminal states and unreachable encodings all fall back to FETCH.
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        // NOTE: default every field first so no path through the case leaves a value unassigned (no latch).
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
                c.pc_write  = 1'b1;
                c.pc_source = 2'b00;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b00;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for(S_FETCH);
        end else begin
            state_q <= next_state(state_q, Op);
            ctrl_q  <= ctrl_for(next_state(state_q, Op));
        end
    end

    assign PCWrite     = ctrl_q.pc_write      & ~reset;
    assign PCWriteCond = ctrl_q.pc_write_cond & ~reset;
    assign MemRead     = ctrl_q.mem_read      & ~reset;
    assign MemWrite    = ctrl_q.mem_write     & ~reset;
    assign IRWrite     = ctrl_q.ir_write      & ~reset;
    assign RegWrite    = ctrl_q.reg_write     & ~reset;
    assign IorD        = ctrl_q.ior_d;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign RegDst      = ctrl_q.reg_dst;
    assign PCSource    = ctrl_q.pc_source;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign state       = state_q;

    assign illegal_op = (state_q == S_DECODE) & ~op_supported(Op) & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed per-cycle vector table,
// reset corner cases, and random instruction streams against a latency/strobe model.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;

    int vectors    = 0;
    int miscompares = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Strobe order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA RegWrite RegDst
    logic [9:0] strobes;
    assign strobes = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                      MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst};

    localparam logic [9:0] K_FETCH  = 10'b1001001000;
    localparam logic [9:0] K_NONE   = 10'b0000000000;
    localparam logic [9:0] K_ASA    = 10'b0000000100;
    localparam logic [9:0] K_MEMRD  = 10'b0011000000;
    localparam logic [9:0] K_MEMWB  = 10'b0000010010;
    localparam logic [9:0] K_MEMWR  = 10'b0010100000;
    localparam logic [9:0] K_ALUWB  = 10'b0000000011;
    localparam logic [9:0] K_BRANCH = 10'b0100000100;
    localparam logic [9:0] K_JUMP   = 10'b1000000000;
    localparam logic [9:0] K_ADDIWB = 10'b0000000010;

    typedef struct {
        logic [5:0] op;
        int         cyc;
        logic [3:0] st;
        logic [9:0] strb;
        logic [1:0] pcs;
        logic [1:0] asb;
        logic [1:0] aop;
        logic       ill;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two edges, then release at a negedge; returns inside cycle 0 (FETCH).
    task automatic start_instr(input logic [5:0] op);
        reset = 1'b1;
        Op    = op;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic add(input logic [5:0] op, input int cyc, input logic [3:0] st,
                       input logic [9:0] strb, input logic [1:0] pcs,
                       input logic [1:0] asb, input logic [1:0] aop, input logic ill);
        vec_t v;
        v.op = op; v.cyc = cyc; v.st = st; v.strb = strb;
        v.pcs = pcs; v.asb = asb; v.aop = aop; v.ill = ill;
        tbl.push_back(v);
    endtask

    // Reference model: instruction behaviour summarised from the ISA-level rules.
    function automatic int model_latency(input logic [5:0] op);
        case (op)
            OP_LW:                      return 5;
            OP_SW, OP_RTYPE, OP_ADDI:   return 4;
            OP_BEQ, OP_J:               return 3;
            default:                    return 2;
        endcase
    endfunction

    function automatic logic model_legal(input logic [5:0] op);
        logic [5:0] legal [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        foreach (legal[i]) if (legal[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pick [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        reset = 1'b1;
        Op    = 6'd0;

        add(OP_LW,   0, S_FETCH,  K_FETCH,  2'b00, 2'b01, 2'b00, 1'b0);
        add(OP_LW,   1, S_DECODE, K_NONE,   2'b00, 2'b11, 2'b00, 1'b0);
        add(OP_LW,   2, S_MEMADR, K_ASA,    2'b00, 2'b10, 2'b00, 1'b0);
        add(OP_LW,   3, S_MEMRD,  K_MEMRD,  2'b00, 2'b00, 2'b00, 1'b0);
        add(OP_LW,   4, S_MEMWB,  K_MEMWB,  2'b00, 2'b00, 2'b00, 1'b0);
        add(OP_LW,   5, S_FETCH,  K_FETCH,  2'b00, 2'b01, 2'b00, 1'b0);
        add(OP_SW,   2, S_MEMADR, K_ASA,    2'b00, 2'b10, 2'b00, 1'b0);
        add(OP_SW,   3, S_MEMWR,  K_MEMWR,  2'b00, 2'b00, 2'b00, 1'b0);
        add(OP_SW,   4, S_FETCH,  K_FETCH,  2'b00, 2'b01, 2'b00, 1'b0);
        add(OP_RTYPE,2, S_EXEC,   K_ASA,    2'b00, 2'b00, 2'b10, 1'b0);
        add(OP_RTYPE,3, S_ALUWB,  K_ALUWB,  2'b00, 2'b00, 2'b00, 1'b0);
        add(OP_RTYPE,4, S_FETCH,  K_FETCH,  2'b00, 2'b01, 2'b00, 1'b0);
        add(OP_BEQ,  2, S_BRANCH, K_BRANCH, 2'b01, 2'b00, 2'b01, 1'b0);
        add(OP_BEQ,  3, S_FETCH,  K_FETCH,  2'b00, 2'b01, 2'b00, 1'b0);
        add(OP_J,    2, S_JUMP,   K_JUMP,   2'b10, 2'b00, 2'b00, 1'b0);
        add(OP_J,    3, S_FETCH,  K_FETCH,  2'b00, 2'b01, 2'b00, 1'b0);
        add(OP_ADDI, 2, S_ADDIEX, K_ASA,    2'b00, 2'b10, 2'b00, 1'b0);
        add(OP_ADDI, 3, S_ADDIWB, K_ADDIWB, 2'b00, 2'b00, 2'b00, 1'b0);
        add(OP_ADDI, 4, S_FETCH,  K_FETCH,  2'b00, 2'b01, 2'b00, 1'b0);
        add(6'h3f,   1, S_DECODE, K_NONE,   2'b00, 2'b11, 2'b00, 1'b1);
        add(6'h3f,   2, S_FETCH,  K_FETCH,  2'b00, 2'b01, 2'b00, 1'b0);

        foreach (tbl[i]) begin
            start_instr(tbl[i].op);
            repeat (tbl[i].cyc) step();
            check($sformatf("v%0d state", i),   32'(state),      32'(tbl[i].st));
            check($sformatf("v%0d strobes", i), 32'(strobes),    32'(tbl[i].strb));
            check($sformatf("v%0d PCSource", i),32'(PCSource),   32'(tbl[i].pcs));
            check($sformatf("v%0d ALUSrcB", i), 32'(ALUSrcB),    32'(tbl[i].asb));
            check($sformatf("v%0d ALUOp", i),   32'(ALUOp),      32'(tbl[i].aop));
            check($sformatf("v%0d illegal", i), 32'(illegal_op), 32'(tbl[i].ill));
        end

        // Strobes gated while reset is held, selects still show FETCH.
        reset = 1'b1;
        repeat (2) step();
        check("rst state",    32'(state),    32'(S_FETCH));
        check("rst strobes",  32'(strobes),  32'(K_NONE));
        check("rst ALUSrcB",  32'(ALUSrcB),  32'b01);

        // Reset asserted in the middle of MEMWR of a store.
        start_instr(OP_SW);
        repeat (3) step();
        check("sw memwr state", 32'(state),    32'(S_MEMWR));
        check("sw MemWrite",    32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("sw MemWrite gated", 32'(MemWrite), 32'd0);
        check("sw IorD ungated",   32'(IorD),     32'd1);
        step();
        check("sw rst -> FETCH", 32'(state), 32'(S_FETCH));
        reset = 1'b0;
        #1;
        check("post-rst FETCH strobes", 32'(strobes), 32'(K_FETCH));

        // Reset mid-load from MEMRD, then a clean load afterwards.
        start_instr(OP_LW);
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("lw MemRead gated", 32'(MemRead), 32'd0);
        step();
        check("lw rst -> FETCH", 32'(state), 32'(S_FETCH));
        reset = 1'b0;
        #1;

        // Random back-to-back instruction stream, reset occasionally injected.
        for (int n = 0; n < 300; n++) begin
            logic [5:0] cur_op;
            int lat, rw, mw, pcw, mr, pcwc, ill, mid_fetch;
            bit inj;
            int inj_c;
            int r;
            r = $urandom_range(0, 7);
            cur_op = (r < 6) ? pick[r] : 6'($urandom);
            lat = model_latency(cur_op);
            inj = ($urandom_range(0, 19) == 0);
            inj_c = $urandom_range(1, lat - 1);
            check($sformatf("r%0d start FETCH", n), 32'(state), 32'(S_FETCH));
            Op = cur_op;
            if (inj) begin
                repeat (inj_c) step();
                reset = 1'b1;
                #1;
                check($sformatf("r%0d inj gated", n), 32'({MemWrite, RegWrite, PCWrite}), 32'd0);
                step();
                check($sformatf("r%0d inj FETCH", n), 32'(state), 32'(S_FETCH));
                reset = 1'b0;
                #1;
                continue;
            end
            rw = 0; mw = 0; pcw = 0; mr = 0; pcwc = 0; ill = 0; mid_fetch = 0;
            for (int c = 0; c < lat; c++) begin
                rw   += int'(RegWrite);
                mw   += int'(MemWrite);
                pcw  += int'(PCWrite);
                mr   += int'(MemRead);
                pcwc += int'(PCWriteCond);
                ill  += int'(illegal_op);
                if (c > 0 && state == 4'(S_FETCH)) mid_fetch++;
                step();
            end
            check($sformatf("r%0d op=%b latency", n, cur_op), 32'(state), 32'(S_FETCH));
            check($sformatf("r%0d op=%b mid FETCH", n, cur_op), 32'(mid_fetch), 32'd0);
            check($sformatf("r%0d op=%b RegWrite cnt", n, cur_op), 32'(rw),
                  32'((cur_op == OP_LW || cur_op == OP_RTYPE || cur_op == OP_ADDI) ? 1 : 0));
            check($sformatf("r%0d op=%b MemWrite cnt", n, cur_op), 32'(mw),
                  32'((cur_op == OP_SW) ? 1 : 0));
            check($sformatf("r%0d op=%b PCWrite cnt", n, cur_op), 32'(pcw),
                  32'(1 + ((cur_op == OP_J) ? 1 : 0)));
            check($sformatf("r%0d op=%b MemRead cnt", n, cur_op), 32'(mr),
                  32'(1 + ((cur_op == OP_LW) ? 1 : 0)));
            check($sformatf("r%0d op=%b PCWriteCond cnt", n, cur_op), 32'(pcwc),
                  32'((cur_op == OP_BEQ) ? 1 : 0));
            check($sformatf("r%0d op=%b illegal cnt", n, cur_op), 32'(ill),
                  32'(model_legal(cur_op) ? 0 : 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Op  input  6  instruction opcode; stable from the cycle after FETCH.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath control strobes and selects.
REQ-006 PCSource, ALUSrcB  output  2 each  mux selects.
REQ-007 ALUOp  output  2  operation class: 00 add, 01 subtract, 10 use funct; feeds the ALU control decoder.
REQ-008 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-009 state  output  4  current FSM state, for debug.

Function
REQ-010 The block SHALL be a Moore FSM; outputs SHALL depend only on the registered state, except for illegal_op and the reset gating in REQ-027.
REQ-011 Any output not listed for a state SHALL be 0.
REQ-012 FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00; next state DECODE.
REQ-013 DECODE: ALUSrcB=11, ALUOp=00; next state by Op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDIEX
- any other -> FETCH
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Op 100011 -> MEMRD, Op 101011 -> MEMWR.
REQ-015 MEMRD: MemRead=1, IorD=1; next state MEMWB.
REQ-016 MEMWB: RegWrite=1, MemtoReg=1; next state FETCH.
REQ-017 MEMWR: MemWrite=1, IorD=1; next state FETCH.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-019 ALUWB: RegDst=1, RegWrite=1; next state FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state FETCH.
REQ-021 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-022 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB.
REQ-023 ADDIWB: RegWrite=1; next state FETCH.
REQ-024 Instruction latency in cycles, counted from FETCH entry: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-025 illegal_op SHALL be 1 exactly in the DECODE cycle whose Op is unsupported; otherwise 0.
REQ-026 An unreachable state encoding SHALL transition to FETCH on the next edge.

Reset
REQ-027 While reset=1, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite and illegal_op SHALL be forced to 0 combinationally.
REQ-028 A rising edge with reset=1 SHALL load state FETCH from any state; this includes reset mid-instruction.
REQ-029 The first cycle after reset deasserts SHALL be a full FETCH cycle with the REQ-012 outputs.

Structure
REQ-030 The 4-bit state encodings and the six opcode constants SHALL reside in shared package mips_ctrl_pkg, which the ALUOp encodings also use.
REQ-031 The block SHALL have no sub-module: one state register plus next-state and output decode.
REQ-032 Expected size: 150-250 lines of RTL.

Verification
REQ-033 Hold reset 2 cycles, then release with Op=100011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 and MemtoReg=1 only in MEMWB.
REQ-034 Op=000000 -> ALUOp=10 in EXEC; RegDst=1 and RegWrite=1 in ALUWB; back in FETCH 4 cycles after FETCH entry.
REQ-035 Op=000100 -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01; Op=000010 -> JUMP with PCWrite=1, PCSource=10; each returns to FETCH after 3 cycles.
REQ-036 Op=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH, and no write strobe asserted.
REQ-037 Assert reset during MEMWR of sw (Op=101011) -> MemWrite=0 in that same cycle; state=FETCH after the edge.
REQ-038 Op=001000 -> ADDIEX with ALUSrcB=10, then ADDIWB with RegWrite=1, RegDst=0, MemtoReg=0.
